// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage.
// The producer/consumer side uses master and the stage itself uses slave.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       level;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a one-word skid buffer and synchronous flush.
// in_ready comes from registered state only, so out_ready never reaches it combinationally.
module pipe_skid_reg #(
  parameter int          WIDTH  = 32,
  parameter logic [31:0] BUBBLE = 32'h00000013
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  pipe_skid_reg_if.slave bus
);

  localparam logic [WIDTH-1:0] BubbleWord = WIDTH'(BUBBLE);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             inReady, outValid;
  logic             inFire, outFire;

  assign inReady  = (state_q != FULL);
  assign outValid = (state_q != EMPTY);
  assign inFire   = bus.in_valid & inReady;
  assign outFire  = outValid & bus.out_ready;

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = main_q;
  assign bus.level     = state_q;

  // main always holds the oldest word; skid only fills when main is stalled
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (inFire) begin
          main_d  = bus.in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (inFire && outFire) begin
          main_d = bus.in_data;
        end else if (inFire) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (outFire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (outFire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = BubbleWord;
      skid_d  = BubbleWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic,
// compared each cycle against a two-deep FIFO model of the stage.
module tb_pipe_skid_reg;

  localparam logic [31:0] Bubble = 32'h00000013;

  logic clk;
  logic rst;
  logic flush;
  int   checkCount;
  int   passCount;

  // model: words held by the stage in arrival order, plus what out_data shows when empty
  logic [31:0] modelQ[$];
  logic [31:0] staleWord;

  pipe_skid_reg_if #(.WIDTH(32)) bus ();

  pipe_skid_reg #(
    .WIDTH (32),
    .BUBBLE(Bubble)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // drive one cycle of inputs, advance the model, then move past the clock edge
  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [31:0] id, input logic ordy);
    logic inOk, outOk;
    logic [31:0] popped;
    rst           = r;
    flush         = f;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    if (r) begin
      modelQ.delete();
      staleWord = 32'h0;
    end else begin
      inOk  = iv && (modelQ.size() < 2);
      outOk = ordy && (modelQ.size() > 0);
      if (f) begin
        modelQ.delete();
        staleWord = Bubble;
      end else begin
        if (outOk) begin
          popped    = modelQ.pop_front();
          staleWord = popped;
        end
        if (inOk) modelQ.push_back(id);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] expData;
    expData = (modelQ.size() > 0) ? modelQ[0] : staleWord;
    compareVal({tag, ".level"},     {30'd0, bus.level},     32'(modelQ.size()));
    compareVal({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, modelQ.size() < 2});
    compareVal({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, modelQ.size() > 0});
    compareVal({tag, ".out_data"},  bus.out_data,           expData);
  endtask

  initial begin
    checkCount    = 0;
    passCount     = 0;
    staleWord     = 32'h0;
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("reset");
    compareVal("reset.out_data_zero", bus.out_data, 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1);
    checkOutput("stream0");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h87654321, 1'b1);
    checkOutput("stream1");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
    checkOutput("stream2");
    compareVal("stream.last_word", bus.out_data, 32'hCAFEF00D);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("stream_drain");

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
    checkOutput("stall0");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0);
    checkOutput("stall1");
    compareVal("stall.full_level", {30'd0, bus.level}, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0);
    checkOutput("stall2_held");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1);
    checkOutput("unstall0");
    compareVal("unstall.second_word", bus.out_data, 32'h22222222);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1);
    checkOutput("unstall1");
    compareVal("unstall.third_word", bus.out_data, 32'h33333333);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("unstall_drain");

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAAA0001, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hAAAA0002, 1'b0);
    checkOutput("flush_fill");
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h44444444, 1'b0);
    checkOutput("flush");
    compareVal("flush.bubble", bus.out_data, Bubble);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("flush_after");

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h66666666, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h66666667, 1'b1);
    checkOutput("rst_over_flush");
    compareVal("rst_over_flush.zero", bus.out_data, 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h77777777, 1'b0);
    checkOutput("refill_busy");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("drain_stale");
    compareVal("drain_stale.word", bus.out_data, 32'h77777777);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0);
    checkOutput("refill");
    compareVal("refill.word", bus.out_data, 32'h55555555);

    // random traffic: rare reset, occasional flush, varying downstream pressure
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(24) == 0),
                    ($urandom_range(3) != 0), $urandom,
                    (i < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0));
      checkOutput("random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
